// File: rtl/button_oneshot_array_if.sv
// ---------------------------------------------------------------------------
// button_oneshot_array_if
// Bundles the per-channel button inputs and the pulse/level/toggle outputs
// of button_oneshot_array.
//   buttons_n  raw asynchronous buttons, 0 = pressed
//   repeat_en  per-channel auto-repeat enable
//   pulse      one-cycle press/repeat pulse
//   held       debounced pressed level
//   toggle     flips on every pulse
// master: the side that owns the buttons (board / bench).
// slave : the one-shot block itself.
// ---------------------------------------------------------------------------
interface button_oneshot_array_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] buttons_n;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] toggle;

    modport master (
        output buttons_n,
        output repeat_en,
        input  pulse,
        input  held,
        input  toggle
    );

    modport slave (
        input  buttons_n,
        input  repeat_en,
        output pulse,
        output held,
        output toggle
    );
endinterface

// File: rtl/button_oneshot_array.sv
// ---------------------------------------------------------------------------
// button_oneshot_array
// N-channel push-button front end. Each channel synchronises an active-low
// button, debounces it, and emits one single-cycle pulse per press, with an
// optional auto-repeat while the button is held. A toggle bit per channel
// flips together with every pulse.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    button_oneshot_array_if.slave (buttons_n, repeat_en in;
//          pulse, held, toggle out, all outputs registered)
// ---------------------------------------------------------------------------
module button_oneshot_array #(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_oneshot_array_if.slave bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX);

    localparam logic [DB_W-1:0] DB_LAST        = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r   [N_CH];
    logic [DB_W-1:0]        db_cnt_r [N_CH];
    logic [RC_W-1:0]        rc_r     [N_CH];
    state_t                 state_r  [N_CH];
    logic [N_CH-1:0]        stable_r;
    logic [N_CH-1:0]        pulse_r;
    logic [N_CH-1:0]        toggle_r;
    logic [N_CH-1:0]        sync_s;

    // Tap the last synchroniser flop of each channel (1 = pressed).
    always_comb begin
        sync_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            sync_s[i] = sync_r[i][SYNC_STAGES-1];
        end
    end

    // Synchroniser chain and debounce: a new level must persist for
    // DEBOUNCE_CYCLES consecutive cycles before it becomes the stable level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                sync_r[i]   <= '0;
                db_cnt_r[i] <= '0;
            end
            stable_r <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], ~bus.buttons_n[i]};
                if (sync_s[i] != stable_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        stable_r[i] <= sync_s[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Per-channel press/repeat FSM with registered pulse and toggle.
    // Release is tested first so it wins over a repeat pulse in the same
    // cycle; RELEASE always returns to IDLE, giving a one-cycle rearm gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= ST_IDLE;
                rc_r[i]    <= '0;
            end
            pulse_r  <= '0;
            toggle_r <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pulse_r[i] <= 1'b0;
                case (state_r[i])
                    ST_IDLE: begin
                        if (stable_r[i]) begin
                            state_r[i]  <= ST_HOLD;
                            pulse_r[i]  <= 1'b1;
                            toggle_r[i] <= ~toggle_r[i];
                            rc_r[i]     <= '0;
                        end else begin
                            state_r[i] <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (!stable_r[i]) begin
                            state_r[i] <= ST_RELEASE;
                        end else if ((rc_r[i] == RC_DELAY_LAST) && bus.repeat_en[i]) begin
                            state_r[i]  <= ST_REPEAT;
                            pulse_r[i]  <= 1'b1;
                            toggle_r[i] <= ~toggle_r[i];
                            rc_r[i]     <= '0;
                        end else if (rc_r[i] != RC_DELAY_LAST) begin
                            rc_r[i] <= rc_r[i] + RC_W'(1);
                        end else begin
                            rc_r[i] <= rc_r[i];
                        end
                    end
                    ST_REPEAT: begin
                        if (!stable_r[i]) begin
                            state_r[i] <= ST_RELEASE;
                        end else if (!bus.repeat_en[i]) begin
                            // Park in HOLD already saturated so a later
                            // repeat_en rise pulses on the very next edge.
                            state_r[i] <= ST_HOLD;
                            rc_r[i]    <= RC_DELAY_LAST;
                        end else if (rc_r[i] == RC_PERIOD_LAST) begin
                            pulse_r[i]  <= 1'b1;
                            toggle_r[i] <= ~toggle_r[i];
                            rc_r[i]     <= '0;
                        end else begin
                            rc_r[i] <= rc_r[i] + RC_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        state_r[i] <= ST_IDLE;
                        rc_r[i]    <= '0;
                    end
                    default: begin
                        state_r[i] <= ST_IDLE;
                        rc_r[i]    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.pulse  = pulse_r;
    assign bus.held   = stable_r;
    assign bus.toggle = toggle_r;

endmodule
